// File: rtl/enemy_bullet_ctrl_if.sv
// Signal bundle between the enemy bullet controller and its surroundings.
// The master side (game logic) drives the frame tick, fire request and the sprite positions.
// The slave side (the controller) drives the bullet position, the ready flag and the event pulses.
interface enemy_bullet_ctrl_if;
  logic       frame_tick;
  logic       fire;
  logic [7:0] enemyX;
  logic [6:0] enemyY;
  logic [7:0] playerX;
  logic [7:0] bulletX;
  logic [6:0] bulletY;
  logic       active;
  logic       ready;
  logic       hit;
  logic       bottomReached;

  modport master (
    output frame_tick, fire, enemyX, enemyY, playerX,
    input  bulletX, bulletY, active, ready, hit, bottomReached
  );

  modport slave (
    input  frame_tick, fire, enemyX, enemyY, playerX,
    output bulletX, bulletY, active, ready, hit, bottomReached
  );
endinterface

// File: rtl/enemy_bullet_ctrl.sv
// Single enemy projectile on a 160x120 playfield.
// The bullet spawns below the enemy sprite and falls by Step rows per frame tick.
// It retires either on striking the player ship (hit) or on leaving the bottom edge
// (bottomReached). After retiring, a cooldown of Cooldown frame ticks must elapse
// before the next fire request is accepted.
module enemy_bullet_ctrl #(
  parameter int unsigned Step     = 4,
  parameter int unsigned SpawnOfs = 4,
  parameter int unsigned PlayerY  = 108,
  parameter int unsigned PlayerH  = 8,
  parameter int unsigned PlayerW  = 8,
  parameter int unsigned MaxY     = 119,
  parameter int unsigned Cooldown = 20,
  parameter int unsigned CntW     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  enemy_bullet_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StFly} state_e;

  state_e          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic            active_q, active_d;
  logic            hit_q, hit_d;
  logic            bottom_q, bottom_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       ready;
  logic [7:0] ny;
  logic       hit_cond;

  assign ready = (state_q == StIdle) && (cnt_q == '0);

  // Next row is computed in 8 bits so a bullet near the bottom cannot wrap back to the top.
  assign ny = {1'b0, y_q} + 8'(Step);

  // Crossing test over the whole step: the bullet hits if it moves from above the ship's
  // bottom edge to at or below its top edge. A plain overlap test would let it tunnel.
  // The right edge uses 9 bits so a ship near column 255 cannot wrap to a small column.
  assign hit_cond = (ny >= 8'(PlayerY)) &&
                    ({1'b0, y_q} < 8'(PlayerY + PlayerH)) &&
                    ({1'b0, x_q} >= {1'b0, bus.playerX}) &&
                    ({1'b0, x_q} <= ({1'b0, bus.playerX} + 9'(PlayerW - 1)));

  // Next-state logic: launch, cooldown countdown, per-tick advance, and retirement.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    bottom_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Acceptance is decided on the pre-decrement count (ready uses cnt_q).
        if (bus.frame_tick && (cnt_q != '0)) begin
          cnt_d = cnt_q - CntW'(1);
        end
        if (bus.fire && ready) begin
          state_d  = StFly;
          x_d      = bus.enemyX;
          y_d      = bus.enemyY + 7'(SpawnOfs);
          active_d = 1'b1;
        end
      end
      StFly: begin
        if (bus.frame_tick) begin
          if (hit_cond || (ny > 8'(MaxY))) begin
            hit_d    = hit_cond;
            bottom_d = !hit_cond;
            state_d  = StIdle;
            active_d = 1'b0;
            x_d      = '0;
            y_d      = '0;
            cnt_d    = CntW'(Cooldown);
          end else begin
            y_d = ny[6:0];
          end
        end
      end
    endcase
  end

  // State and registered outputs; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      bottom_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      bottom_q <= bottom_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.bulletX       = x_q;
  assign bus.bulletY       = y_q;
  assign bus.active        = active_q;
  assign bus.ready         = ready;
  assign bus.hit           = hit_q;
  assign bus.bottomReached = bottom_q;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Directed bench for enemy_bullet_ctrl with default parameters.
module tb_enemy_bullet_ctrl;
  logic clk;
  logic resetn;
  int   vectors;
  int   miscompares;

  enemy_bullet_ctrl_if bus ();

  enemy_bullet_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given tick/fire levels; returns 1 time unit after the edge.
  task automatic step(input logic ft, input logic fr);
    bus.frame_tick = ft;
    bus.fire       = fr;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.fire       = 1'b0;
  endtask

  task automatic cool();
    repeat (20) step(1'b1, 1'b0);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    resetn         = 1'b0;
    bus.frame_tick = 1'b0;
    bus.fire       = 1'b0;
    bus.enemyX     = 8'd0;
    bus.enemyY     = 7'd0;
    bus.playerX    = 8'd0;

    // Reset state
    #12;
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_x", 32'(bus.bulletX), 0);
    chk("rst_y", 32'(bus.bulletY), 0);
    chk("rst_hit", 32'(bus.hit), 0);
    chk("rst_bottom", 32'(bus.bottomReached), 0);
    resetn = 1'b1;
    step(1'b0, 1'b0);
    chk("rst_ready", 32'(bus.ready), 1);

    // Reset mid-flight
    bus.enemyX = 8'd50;
    bus.enemyY = 7'd20;
    step(1'b0, 1'b1);
    chk("mf_spawn_x", 32'(bus.bulletX), 50);
    chk("mf_spawn_y", 32'(bus.bulletY), 24);
    repeat (3) step(1'b1, 1'b0);
    chk("mf_y3", 32'(bus.bulletY), 36);
    #2;
    resetn = 1'b0;
    #1;
    chk("mf_async_active", 32'(bus.active), 0);
    chk("mf_async_x", 32'(bus.bulletX), 0);
    chk("mf_async_y", 32'(bus.bulletY), 0);
    #1;
    resetn = 1'b1;
    step(1'b0, 1'b0);
    chk("mf_ready", 32'(bus.ready), 1);

    // Spawn and step
    bus.enemyX = 8'd40;
    bus.enemyY = 7'd10;
    step(1'b0, 1'b1);
    chk("sp_active", 32'(bus.active), 1);
    chk("sp_x", 32'(bus.bulletX), 40);
    chk("sp_y", 32'(bus.bulletY), 14);
    chk("sp_ready_fly", 32'(bus.ready), 0);
    step(1'b1, 1'b0);
    chk("sp_y1", 32'(bus.bulletY), 18);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("sp_hold", 32'(bus.bulletY), 18);
    repeat (4) step(1'b1, 1'b0);
    chk("sp_y5", 32'(bus.bulletY), 34);
    // Fire and enemy movement during flight are ignored
    bus.enemyX = 8'd99;
    bus.enemyY = 7'd60;
    step(1'b0, 1'b1);
    chk("fly_fire_x", 32'(bus.bulletX), 40);
    chk("fly_fire_y", 32'(bus.bulletY), 34);

    // Hit with crossing: 34 -> 106 in 18 ticks, then 106 -> 110 crosses row 108
    bus.playerX = 8'd36;
    repeat (18) step(1'b1, 1'b0);
    chk("hit_pre_y", 32'(bus.bulletY), 106);
    chk("hit_pre_hit", 32'(bus.hit), 0);
    chk("hit_pre_active", 32'(bus.active), 1);
    step(1'b1, 1'b0);
    chk("hit_pulse", 32'(bus.hit), 1);
    chk("hit_bottom", 32'(bus.bottomReached), 0);
    chk("hit_active", 32'(bus.active), 0);
    chk("hit_x", 32'(bus.bulletX), 0);
    chk("hit_ready", 32'(bus.ready), 0);
    step(1'b0, 1'b0);
    chk("hit_one_cycle", 32'(bus.hit), 0);

    // Cooldown gating with fire held every cycle
    bus.enemyX = 8'd40;
    bus.enemyY = 7'd112;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      chk("cd_ignored", 32'(bus.active), 0);
      step(1'b1, 1'b1);
      chk("cd_ignored_tick", 32'(bus.active), 0);
    end
    chk("cd_ready", 32'(bus.ready), 1);
    step(1'b0, 1'b1);
    chk("cd_accept", 32'(bus.active), 1);
    chk("cd_y", 32'(bus.bulletY), 116);

    // Miss and bottom: 116 -> 120 > 119
    bus.playerX = 8'd100;
    step(1'b1, 1'b0);
    chk("bot_pulse", 32'(bus.bottomReached), 1);
    chk("bot_hit", 32'(bus.hit), 0);
    chk("bot_active", 32'(bus.active), 0);
    step(1'b0, 1'b0);
    chk("bot_one_cycle", 32'(bus.bottomReached), 0);
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b0);
      chk("bot_cd_busy", 32'(bus.ready), 0);
    end
    step(1'b1, 1'b0);
    chk("bot_cd_done", 32'(bus.ready), 1);

    // Right edge column: bulletX = playerX + 7 hits
    bus.playerX = 8'd33;
    bus.enemyX  = 8'd40;
    bus.enemyY  = 7'd100;
    step(1'b0, 1'b1);
    chk("edge7_y", 32'(bus.bulletY), 104);
    step(1'b1, 1'b0);
    chk("edge7_hit", 32'(bus.hit), 1);
    cool();

    // bulletX = playerX + 8 misses and falls to the bottom
    bus.playerX = 8'd32;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("edge8_nohit", 32'(bus.hit), 0);
    chk("edge8_y", 32'(bus.bulletY), 108);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("edge8_y116", 32'(bus.bulletY), 116);
    step(1'b1, 1'b0);
    chk("edge8_bottom", 32'(bus.bottomReached), 1);
    chk("edge8_hit_end", 32'(bus.hit), 0);
    cool();

    // playerX = 155: bullet at column 2 must not match
    bus.playerX = 8'd155;
    bus.enemyX  = 8'd2;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("p155_nohit", 32'(bus.hit), 0);
    chk("p155_y", 32'(bus.bulletY), 108);
    step(1'b1, 1'b0);
    chk("p155_nohit2", 32'(bus.hit), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("p155_bottom", 32'(bus.bottomReached), 1);
    cool();

    // playerX = 250: right edge 257 needs the 9th bit to cover column 252
    bus.playerX = 8'd250;
    bus.enemyX  = 8'd252;
    step(1'b0, 1'b1);
    chk("p250_x", 32'(bus.bulletX), 252);
    step(1'b1, 1'b0);
    chk("p250_hit", 32'(bus.hit), 1);
    chk("p250_bottom", 32'(bus.bottomReached), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
